mac_dot_sequencer: RTL and testbench

Drives the MAC unit's operand interface to compute a dot product of two vectors up to DEPTH elements long. Vectors are preloaded into an internal operand buffer. A command selects the length; the block then clears the accumulator and issues one operand pair per MAC completion. The final accumulator value is returned on a valid/ready result port. It sits between the host/control logic and the MAC unit, acting as the initiator of the MAC's start/ready protocol.

---
 rtl/mac_dot_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: walks a preloaded operand buffer through the MAC
// start/ready protocol and returns the accumulated dot product.
module mac_dot_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT    = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_a_i,
  input  logic [DATA_WIDTH-1:0] wr_b_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [AW:0]           cmd_len_i,
  output logic                  mac_start_o,
  output logic                  mac_clr_acc_o,
  output logic [DATA_WIDTH-1:0] mac_a_o,
  output logic [DATA_WIDTH-1:0] mac_b_o,
  input  logic                  mac_ready_i,
  input  logic [ACC_WIDTH-1:0]  mac_acc_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [ACC_WIDTH-1:0]  res_data_o,
  output logic                  res_err_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   MAX_LEN = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [AW:0]          len_q, len_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] res_q, res_d;
  logic                 err_q, err_d;

  logic [DATA_WIDTH-1:0] buf_a [DEPTH];
  logic [DATA_WIDTH-1:0] buf_b [DEPTH];

  logic len_ok;
  logic last_elem;
  logic wr_ok;

  assign len_ok    = (cmd_len_i != '0) && (cmd_len_i <= MAX_LEN);
  assign last_elem = ({1'b0, idx_q} == (len_q - 1'b1));
  assign wr_ok     = wr_en_i && (state_q == S_IDLE);

  assign busy_o     = (state_q != S_IDLE);
  assign res_data_o = res_q;
  assign res_err_o  = err_q;

  // Operand storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      buf_a[wr_addr_i] <= wr_a_i;
      buf_b[wr_addr_i] <= wr_b_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    res_d         = res_q;
    err_d         = err_q;
    cmd_ready_o   = 1'b0;
    mac_start_o   = 1'b0;
    mac_clr_acc_o = 1'b0;
    mac_a_o       = '0;
    mac_b_o       = '0;
    res_valid_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Not ready while reset is still asserted.
        cmd_ready_o = rst_n;
        if (cmd_valid_i) begin
          len_d = cmd_len_i;
          idx_d = '0;
          if (len_ok) begin
            state_d = S_CLEAR;
          end else begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESULT;
          end
        end
      end
      S_CLEAR: begin
        mac_clr_acc_o = 1'b1;
        state_d       = S_ISSUE;
      end
      S_ISSUE: begin
        mac_start_o = 1'b1;
        mac_a_o     = buf_a[idx_q];
        mac_b_o     = buf_b[idx_q];
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mac_ready_i) begin
          if (last_elem) begin
            res_d   = mac_acc_i;
            err_d   = 1'b0;
            state_d = S_RESULT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else if (cnt_q == TO_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a simple two-cycle MAC model
// and immediate-assertion checks.
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_a, wr_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_len;
  logic        mac_start;
  logic        mac_clr_acc;
  logic [15:0] mac_a, mac_b;
  logic        mac_ready;
  logic [39:0] mac_acc;
  logic        res_valid;
  logic        res_ready;
  logic [39:0] res_data;
  logic        res_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_dot_sequencer #(
    .DATA_WIDTH(16),
    .ACC_WIDTH (40),
    .DEPTH     (16),
    .TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_a_i       (wr_a),
    .wr_b_i       (wr_b),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_len_i    (cmd_len),
    .mac_start_o  (mac_start),
    .mac_clr_acc_o(mac_clr_acc),
    .mac_a_o      (mac_a),
    .mac_b_o      (mac_b),
    .mac_ready_i  (mac_ready),
    .mac_acc_i    (mac_acc),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_err_o    (res_err),
    .busy_o       (busy)
  );

  // MAC model: ready two cycles after each start
  logic       mac_en;
  logic       force_rdy;
  logic       mdl_rdy;
  logic [1:0] dly;
  logic [39:0] acc;

  assign mac_ready = mdl_rdy | force_rdy;
  assign mac_acc   = acc;

  always @(posedge clk) begin
    mdl_rdy <= 1'b0;
    if (!rst_n) begin
      dly <= '0;
      acc <= '0;
    end else begin
      if (mac_clr_acc) acc <= '0;
      if (mac_start) begin
        acc <= acc + ({{24{mac_a[15]}}, mac_a} * {{24{mac_b[15]}}, mac_b});
        dly <= 2'd1;
      end else if (dly != 2'd0) begin
        dly <= dly - 2'd1;
        if (dly == 2'd1 && mac_en) mdl_rdy <= 1'b1;
      end
    end
  end

  // Pulse monitor
  int n_start = 0;
  int n_clr   = 0;
  logic [15:0] sa [64];
  logic [15:0] sb [64];

  always @(posedge clk) begin
    if (mac_start) begin
      sa[n_start[5:0]] <= mac_a;
      sb[n_start[5:0]] <= mac_b;
      n_start <= n_start + 1;
    end
    if (mac_clr_acc) n_clr <= n_clr + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] a,
                    input logic [15:0] b);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_a    = a;
    wr_b    = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic run_cmd(input logic [4:0] len, output int cyc,
                         output logic clr1, output logic st2);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc  = 1;
    clr1 = mac_clr_acc;
    st2  = 1'b0;
    while (!res_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) st2 = mac_start;
    end
    chk("res_valid_seen", res_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   bs, bc, k;
    logic clr1, st2;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    cmd_valid = 1'b0; cmd_len = '0; res_ready = 1'b1;
    mac_en = 1'b1; force_rdy = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mac_start", mac_start, 0);
    chk("rst_mac_clr", mac_clr_acc, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Vector dot product
    wr(4'd0, 16'd1, 16'd5);
    wr(4'd1, 16'd2, 16'd6);
    wr(4'd2, 16'd3, 16'd7);
    wr(4'd3, 16'd4, 16'd8);
    bs = n_start; bc = n_clr;
    run_cmd(5'd4, cyc, clr1, st2);
    chk("vec_clr_t1", clr1, 1);
    chk("vec_start_t2", st2, 1);
    chk("vec_latency", cyc, 14);
    chk("vec_data", res_data, 40'd70);
    chk("vec_err", res_err, 0);
    chk("vec_nclr", n_clr - bc, 1);
    chk("vec_nstart", n_start - bs, 4);
    for (int i = 0; i < 4; i++) begin
      chk("vec_pair_a", sa[bs + i], 64'(i + 1));
      chk("vec_pair_b", sb[bs + i], 64'(i + 5));
    end
    @(negedge clk);
    chk("vec_done_valid", res_valid, 0);
    chk("vec_done_busy", busy, 0);

    // Illegal lengths
    bs = n_start; bc = n_clr;
    run_cmd(5'd0, cyc, clr1, st2);
    chk("len0_latency", cyc, 1);
    chk("len0_err", res_err, 1);
    chk("len0_data", res_data, 0);
    @(negedge clk);
    run_cmd(5'd17, cyc, clr1, st2);
    chk("len17_latency", cyc, 1);
    chk("len17_err", res_err, 1);
    chk("len17_data", res_data, 0);
    @(negedge clk);
    chk("illegal_nclr", n_clr - bc, 0);
    chk("illegal_nstart", n_start - bs, 0);

    // Signed single element under result backpressure
    wr(4'd0, 16'hFFFD, 16'h0007);
    res_ready = 1'b0;
    run_cmd(5'd1, cyc, clr1, st2);
    chk("sgn_latency", cyc, 5);
    chk("sgn_data", res_data, 40'hFFFFFFFFEB);
    chk("sgn_err", res_err, 0);
    bc = n_clr;
    cmd_valid = 1'b1; cmd_len = 5'd1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_a = 16'h1111; wr_b = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 40'hFFFFFFFFEB);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0; wr_en = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", res_valid, 0);
    chk("bp_idle", busy, 0);
    chk("bp_nclr", n_clr - bc, 0);
    run_cmd(5'd1, cyc, clr1, st2);
    chk("bp_buf_unchanged", res_data, 40'hFFFFFFFFEB);
    @(negedge clk);

    // Timeout, then a stray ready in IDLE
    mac_en = 1'b0;
    bs = n_start;
    run_cmd(5'd1, cyc, clr1, st2);
    chk("to_latency", cyc, 11);
    chk("to_err", res_err, 1);
    chk("to_data", res_data, 0);
    chk("to_nstart", n_start - bs, 1);
    @(negedge clk);
    mac_en = 1'b1;
    force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_valid", res_valid, 0);
    chk("stray_nstart", n_start - bs, 1);
    @(negedge clk);
    chk("stray_idle", busy, 0);

    // Reset in WAIT of element 2
    wr(4'd0, 16'd1, 16'd5);
    chk("rm_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_len = 5'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!(mac_start && mac_a == 16'd2) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rm_second_start", mac_start, 1);
    @(negedge clk);
    chk("rm_in_wait", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_cmd_ready", cmd_ready, 0);
    chk("rm_busy", busy, 0);
    chk("rm_mac_start", mac_start, 0);
    chk("rm_mac_clr", mac_clr_acc, 0);
    chk("rm_mac_a", mac_a, 0);
    chk("rm_res_valid", res_valid, 0);
    chk("rm_res_data", res_data, 0);
    chk("rm_res_err", res_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rm_ready_again", cmd_ready, 1);
    run_cmd(5'd4, cyc, clr1, st2);
    chk("rm_rerun_data", res_data, 40'd70);
    chk("rm_rerun_err", res_err, 0);
    chk("rm_rerun_latency", cyc, 14);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
